alu_operand_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_operand_arbiter_rr_pick4.sv | 32 +++
 rtl/mux4to1.sv | 24 ++
 rtl/alu_operand_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_operand_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU operand arbiter.
//   NUM_REQ      number of requesters sharing the operand bus
//   arb_state_t  arbiter FSM state (IDLE / BUSY)
//   SEL_REQ0..3  mux select encodings, equal to the requester index
//   onehot4()    index -> one-hot grant vector
package alu_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_REQ3 = 2'b11;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/alu_operand_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way rotating picker.
//   req_i    request vector
//   start_i  index searched first; search continues start+1, start+2 ... mod 4
//   excl_i   mask of requesters that may not win this pick
//   idx_o    winning index (0 when nothing found)
//   found_o  a winner exists
module rr_pick4
    import alu_arb_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] start_i,
    input  logic [3:0] excl_i,
    output logic [1:0] idx_o,
    output logic       found_o
);

    logic [1:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = start_i + 2'(i);
            if (!found_o && req_i[cand] && !excl_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4to1.sv
// mux4to1: single-bit 4:1 multiplexer.
//   a,b,c,d  data inputs selected by sel = 0,1,2,3
//   sel      2-bit binary select
//   y        selected bit
module mux4to1 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        y = a;
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/alu_operand_arbiter.sv
// alu_operand_arbiter: shares one ALU operand bus between four requesters
// (0 decode, 1 forwarding, 2 load return, 3 debug) with a per-grant hold limit.
//   clk, rst        clock, asynchronous active-high reset
//   req[3:0]        level requests
//   A, B, C, D      requester data, WIDTH bits each
//   gnt[3:0]        registered one-hot grant
//   S1, S0          registered mux select (binary index of the grant owner)
//   Out             data selected by {S1,S0}, combinational
//   out_valid       registered, high while gnt is non-zero
// Build option: ARB_FIXED_PRIO_EN selects fixed priority 0>1>2>3 (a higher
// priority request preempts the owner; the hold limit still forces a release
// that excludes the owner for that one arbitration). Default is round-robin.
//
// state | meaning
// IDLE  | no grant
// BUSY  | one owner granted, cnt counts its consecutive cycles
module alu_operand_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       gnt,
    output logic             S1,
    output logic             S0,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    arb_state_t state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q;

    logic [1:0] pick_start;
    logic [3:0] pick_excl;
    logic [1:0] win_idx;
    logic       win_found;
    logic       release_w;
    logic       grant_en;
    logic [1:0] grant_idx;

    // ptr_q is the current owner while BUSY, the last owner while IDLE
    assign release_w = !req[ptr_q] || (cnt_q >= HOLD_LIM);

    always_comb begin
        pick_start = '0;
        pick_excl  = '0;
`ifdef ARB_FIXED_PRIO_EN
        pick_start = SEL_REQ0;
        if (state_q == BUSY && release_w) pick_excl = onehot4(ptr_q);
`else
        pick_start = ptr_q + 2'd1;
        if (state_q == BUSY) pick_excl = onehot4(ptr_q);
`endif
    end

    rr_pick4 u_pick (
        .req_i   (req),
        .start_i (pick_start),
        .excl_i  (pick_excl),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_en  = 1'b0;
        grant_idx = win_idx;

        case (state_q)
            IDLE: begin
                grant_en = win_found;
            end
            default: begin
                if (release_w) begin
                    if (win_found) begin
                        grant_en = 1'b1;
                    end else if (req[ptr_q]) begin
                        grant_en  = 1'b1;
                        grant_idx = ptr_q;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
`ifdef ARB_FIXED_PRIO_EN
                    if (win_found && win_idx != ptr_q) grant_en = 1'b1;
`endif
                    if (cnt_q < HOLD_LIM) cnt_d = cnt_q + 4'd1;
                end
            end
        endcase

        if (grant_en) begin
            gnt_d   = onehot4(grant_idx);
            sel_d   = grant_idx;
            ptr_d   = grant_idx;
            cnt_d   = 4'd1;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= SEL_REQ0;
            ptr_q   <= SEL_REQ3;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= |gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign S1        = sel_q[1];
    assign S0        = sel_q[0];
    assign out_valid = valid_q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_mux
        mux4to1 u_mux (
            .a   (A[b]),
            .b   (B[b]),
            .c   (C[b]),
            .d   (D[b]),
            .sel (sel_q),
            .y   (Out[b])
        );
    end

endmodule

// File: tb/tb_alu_operand_arbiter.sv
module tb_alu_operand_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] A, B, C, D;
    logic [3:0]  gnt;
    logic        S1, S0;
    logic [31:0] Out;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    alu_operand_arbiter #(.WIDTH(32), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .gnt       (gnt),
        .S1        (S1),
        .S0        (S0),
        .Out       (Out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        step();
        step();
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++;
        if ({S1, S0} !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", {S1, S0}); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (Out !== A) begin errors++; $display("FAIL reset_out got=%h exp=%h", Out, A); end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt got=%b exp=0001", gnt); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", out_valid); end
        checks++;
        if (Out !== A) begin errors++; $display("FAIL first_out got=%h exp=%h", Out, A); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data [4];
        logic [1:0]  idx;
        exp_data[0] = A; exp_data[1] = B; exp_data[2] = C; exp_data[3] = D;
        reset_dut(4'b1111);
        for (int k = 0; k < 17; k++) begin
            step();
            idx = 2'((k / 4) % 4);
            checks++;
            if (gnt !== (4'b0001 << idx)) begin
                errors++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", k, gnt, 4'b0001 << idx);
            end
            checks++;
            if ({S1, S0} !== idx || Out !== exp_data[idx]) begin
                errors++; $display("FAIL rr_sel cyc=%0d got=%b/%h exp=%b/%h", k, {S1, S0}, Out, idx, exp_data[idx]);
            end
        end
    endtask

    task automatic test_fixed_prio();
        logic [3:0] exp_g;
        reset_dut(4'b1010);
        for (int k = 0; k < 18; k++) begin
            step();
            exp_g = ((k % 5) < 4) ? 4'b0010 : 4'b1000;
            checks++;
            if (gnt !== exp_g) begin
                errors++; $display("FAIL fp_gnt cyc=%0d got=%b exp=%b", k, gnt, exp_g);
            end
        end
    endtask

    task automatic test_single_hold();
        reset_dut(4'b0100);
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (gnt !== 4'b0100 || out_valid !== 1'b1) begin
                errors++; $display("FAIL hold_gnt cyc=%0d got=%b/%b exp=0100/1", k, gnt, out_valid);
            end
            checks++;
            if (Out !== 32'hDEADBEEF) begin
                errors++; $display("FAIL hold_out cyc=%0d got=%h exp=deadbeef", k, Out);
            end
        end
    endtask

    task automatic test_owner_drop();
        reset_dut(4'b1010);
        step();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_first got=%b exp=0010", gnt); end
        step();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_hold got=%b exp=0010", gnt); end
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_switch got=%b exp=1000", gnt); end
        checks++;
        if ({S1, S0} !== 2'b11 || Out !== D) begin
            errors++; $display("FAIL drop_sel got=%b/%h exp=11/%h", {S1, S0}, Out, D);
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_gnt got=%b/%b exp=0000/0", gnt, out_valid);
        end
        checks++;
        if ({S1, S0} !== 2'b11) begin errors++; $display("FAIL idle_sel got=%b exp=11", {S1, S0}); end
    endtask

    task automatic test_reset_mid_grant();
        reset_dut(4'b1000);
        step();
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL mid_pre got=%b exp=1000", gnt); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_async got=%b/%b exp=0000/0", gnt, out_valid);
        end
        checks++;
        if ({S1, S0} !== 2'b00) begin errors++; $display("FAIL mid_sel got=%b exp=00", {S1, S0}); end
        req = 4'b1111;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_restart got=%b exp=0001", gnt); end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        A = 32'h1111_AAAA;
        B = 32'h2222_BBBB;
        C = 32'hDEADBEEF;
        D = 32'h4444_DDDD;
        step();
        test_reset();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_single_hold();
        test_owner_drop();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
